// File: rtl/y_adder1.sv
// Ripple-carry full adder built from a replicated 1-bit cell, with an optional
// asynchronously reset output register on z/cout.
module y_adder1 #(
    parameter int unsigned WIDTH   = 1,
    parameter bit          REG_OUT = 1'b0
) (
    output logic [WIDTH-1:0] z,
    output logic             cout,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             clk,
    input  logic             rst_n
);

    logic [WIDTH-1:0] s;
    logic [WIDTH:0]   c;

    // Bitwise cell equations keep X/Z on any input visible on the outputs.
    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    generate
        if (REG_OUT) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    z    <= '0;
                    cout <= 1'b0;
                end else begin
                    z    <= s;
                    cout <= c[WIDTH];
                end
            end
        end else begin : g_comb
            // clk/rst_n are intentionally ignored in the combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign z    = s;
            assign cout = c[WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_y_adder1.sv
// Bench for y_adder1: combinational and registered builds at several widths,
// compared against plain integer addition.
module tb_y_adder1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Deliberately unknown clock/reset for the combinational builds.
    logic clk_x = 1'bx;
    logic rst_x = 1'bx;

    // WIDTH=1, combinational
    logic       a1, b1, ci1, z1, co1;
    // WIDTH=4, combinational
    logic [3:0] a4, b4, z4;
    logic       ci4, co4;
    // WIDTH=8, combinational
    logic [7:0] a8, b8, z8;
    logic       ci8, co8;
    // WIDTH=1, registered
    logic       ar1, br1, cir1, zr1, cor1, rst_r1;
    // WIDTH=4, registered
    logic [3:0] ar4, br4, zr4;
    logic       cir4, cor4, rst_r4;

    y_adder1 #(.WIDTH(1), .REG_OUT(1'b0)) u_c1 (
        .z(z1), .cout(co1), .a(a1), .b(b1), .cin(ci1), .clk(clk_x), .rst_n(rst_x));
    y_adder1 #(.WIDTH(4), .REG_OUT(1'b0)) u_c4 (
        .z(z4), .cout(co4), .a(a4), .b(b4), .cin(ci4), .clk(clk_x), .rst_n(rst_x));
    y_adder1 #(.WIDTH(8), .REG_OUT(1'b0)) u_c8 (
        .z(z8), .cout(co8), .a(a8), .b(b8), .cin(ci8), .clk(clk_x), .rst_n(rst_x));
    y_adder1 #(.WIDTH(1), .REG_OUT(1'b1)) u_r1 (
        .z(zr1), .cout(cor1), .a(ar1), .b(br1), .cin(cir1), .clk(clk), .rst_n(rst_r1));
    y_adder1 #(.WIDTH(4), .REG_OUT(1'b1)) u_r4 (
        .z(zr4), .cout(cor4), .a(ar4), .b(br4), .cin(cir4), .clk(clk), .rst_n(rst_r4));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: unsigned sum as {carry, sum}, truncated to w+1 bits.
    function automatic logic [63:0] ref_add(input int unsigned w, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin);
        logic [63:0] full;
        full = 64'(a) + 64'(b) + 64'(cin);
        return full & ((64'd1 << (w + 1)) - 64'd1);
    endfunction

    logic [63:0] exp_r4;

    initial begin
        {a1, b1, ci1} = '0;
        {a4, b4, ci4} = '0;
        {a8, b8, ci8} = '0;
        {ar1, br1, cir1} = 3'b111;
        {ar4, br4, cir4} = '0;
        rst_r1 = 1'b0;
        rst_r4 = 1'b0;

        // Reset holds registered outputs low before any clock edge
        #1;
        check("r1_reset_noclk", {cor1, zr1}, 2'b00);
        check("r4_reset_noclk", {cor4, zr4}, 5'h00);

        // Exhaustive 1-bit sweep
        for (int i = 0; i < 8; i++) begin
            {a1, b1, ci1} = 3'(i);
            #1;
            check($sformatf("c1_sweep_%0d", i), {co1, z1}, ref_add(1, 32'(a1), 32'(b1), ci1));
        end

        // Only cin changes: outputs follow without a clock
        {a1, b1, ci1} = 3'b100;
        #1 check("c1_cin_lo", {co1, z1}, 2'b01);
        ci1 = 1'b1;
        #1 check("c1_cin_hi", {co1, z1}, 2'b10);

        // X on an input is not masked
        a1 = 1'bx; b1 = 1'b0; ci1 = 1'b0;
        #1 check("c1_x_prop", {co1, z1}, 2'b0x);
        a1 = 1'b0;

        // Full ripple and a plain sum on WIDTH=4
        a4 = 4'hF; b4 = 4'h0; ci4 = 1'b1;
        #1 check("c4_ripple", {co4, z4}, 5'h10);
        a4 = 4'h5; b4 = 4'h3; ci4 = 1'b0;
        #1 check("c4_5p3", {co4, z4}, 5'h08);

        // Random sums on WIDTH=4 and WIDTH=8
        for (int i = 0; i < 40; i++) begin
            a4 = 4'($urandom); b4 = 4'($urandom); ci4 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
            if (i == 0) begin a8 = 8'hFF; b8 = 8'h00; ci8 = 1'b1; end
            if (i == 1) begin a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1; end
            #1;
            check("c4_rand", {co4, z4}, ref_add(4, 32'(a4), 32'(b4), ci4));
            check("c8_rand", {co8, z8}, ref_add(8, 32'(a8), 32'(b8), ci8));
        end

        // Registered WIDTH=1: release reset, one edge captures 1+1+1
        @(negedge clk);
        rst_r1 = 1'b1;
        #1 check("r1_released_noedge", {cor1, zr1}, 2'b00);
        @(posedge clk);
        #1 check("r1_first_capture", {cor1, zr1}, 2'b11);

        // Inputs changed between edges do not reach the outputs
        {ar1, br1, cir1} = 3'b001;
        #1 check("r1_hold_between_edges", {cor1, zr1}, 2'b11);
        @(posedge clk);
        #1 check("r1_second_capture", {cor1, zr1}, 2'b01);

        // Mid-cycle reset drops outputs immediately and holds across an edge
        #2 rst_r1 = 1'b0;
        #1 check("r1_async_reset", {cor1, zr1}, 2'b00);
        @(posedge clk);
        #1 check("r1_reset_held", {cor1, zr1}, 2'b00);
        @(negedge clk) rst_r1 = 1'b1;
        @(posedge clk);
        #1 check("r1_after_rerelease", {cor1, zr1}, 2'b01);

        // Registered WIDTH=4: random operands with occasional reset pulses
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ar4 = 4'($urandom); br4 = 4'($urandom); cir4 = 1'($urandom);
            rst_r4 = ($urandom_range(0, 7) != 0);
            if (i == 0) rst_r4 = 1'b1;
            exp_r4 = rst_r4 ? ref_add(4, 32'(ar4), 32'(br4), cir4) : 64'd0;
            if (!rst_r4) begin
                #1 check("r4_async_reset", {cor4, zr4}, 5'h00);
            end
            @(posedge clk);
            #1 check("r4_rand", {cor4, zr4}, exp_r4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
